riscv_dcache_fsm: RTL and testbench

- Control state machine for the direct-mapped, write-back, write-allocate data cache.
- Sits between the core load/store port and the backing data memory, beside the dcache tag/data arrays.
- Decides hit/miss, drives victim writeback and line refill handshakes, and stalls the pipeline until the access completes.
- Sized by the dcache package parameters: 128-bit lines, 16 B per block, 256-line depth at 4 KiB.

---
 rtl/riscv_dcache_fsm_if.sv | 45 ++++
 rtl/riscv_dcache_fsm.sv | 120 ++++++++++++
 tb/tb_riscv_dcache_fsm.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/riscv_dcache_fsm_if.sv
// Core/memory/tag-array handshake bundle for the dcache control FSM.
// Counter ports exist only when DCACHE_PERF_CNT_EN is defined.
interface riscv_dcache_fsm_if #(
    parameter int CNT_WIDTH = 32
);
    logic i_dcache_cpu_rden;
    logic i_dcache_cpu_wren;
    logic i_dcache_tag_hit;
    logic i_dcache_tag_dirty;
    logic i_dcache_mem_ready;
    logic o_dcache_stall;
    logic o_dcache_mem_rden;
    logic o_dcache_mem_wren;
    logic o_dcache_addr_sel;
    logic o_dcache_cache_wren;
    logic o_dcache_refill_wren;
    logic o_dcache_set_dirty;
    logic o_dcache_set_valid;
`ifdef DCACHE_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] o_dcache_hit_cnt;
    logic [CNT_WIDTH-1:0] o_dcache_miss_cnt;
`endif

    modport slave (
        input  i_dcache_cpu_rden, i_dcache_cpu_wren, i_dcache_tag_hit,
               i_dcache_tag_dirty, i_dcache_mem_ready,
        output o_dcache_stall, o_dcache_mem_rden, o_dcache_mem_wren,
               o_dcache_addr_sel, o_dcache_cache_wren, o_dcache_refill_wren,
               o_dcache_set_dirty, o_dcache_set_valid
`ifdef DCACHE_PERF_CNT_EN
        , output o_dcache_hit_cnt, o_dcache_miss_cnt
`endif
    );

    modport master (
        output i_dcache_cpu_rden, i_dcache_cpu_wren, i_dcache_tag_hit,
               i_dcache_tag_dirty, i_dcache_mem_ready,
        input  o_dcache_stall, o_dcache_mem_rden, o_dcache_mem_wren,
               o_dcache_addr_sel, o_dcache_cache_wren, o_dcache_refill_wren,
               o_dcache_set_dirty, o_dcache_set_valid
`ifdef DCACHE_PERF_CNT_EN
        , input o_dcache_hit_cnt, o_dcache_miss_cnt
`endif
    );
endinterface

// File: rtl/riscv_dcache_fsm.sv
// Control FSM for the direct-mapped write-back/write-allocate dcache.
// Optional hit/miss counters enabled by macro DCACHE_PERF_CNT_EN.
module riscv_dcache_fsm #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR       = 27,
    parameter int CNT_WIDTH  = 32
) (
    input  logic              i_riscv_dcache_clk,
    input  logic              i_riscv_dcache_rst,
    riscv_dcache_fsm_if.slave bus
);
    localparam int LINE_BYTES = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_ALLOC = 2'd2;

    generate
        if (LINE_BYTES < 1 || ADDR < 1 || CNT_WIDTH < 1) begin : g_bad_cfg
            $error("riscv_dcache_fsm: invalid parameterisation");
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_req;
    logic       w_store;
    logic       w_stall, w_mem_rden, w_mem_wren, w_addr_sel;
    logic       w_cache_wren, w_refill_wren, w_set_dirty, w_set_valid;

    assign w_req   = bus.i_dcache_cpu_rden | bus.i_dcache_cpu_wren;
    assign w_store = bus.i_dcache_cpu_wren;

    always_comb begin
        w_next        = r_state;
        w_stall       = 1'b0;
        w_mem_rden    = 1'b0;
        w_mem_wren    = 1'b0;
        w_addr_sel    = 1'b0;
        w_cache_wren  = 1'b0;
        w_refill_wren = 1'b0;
        w_set_dirty   = 1'b0;
        w_set_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (bus.i_dcache_tag_hit) begin
                        w_cache_wren = w_store;
                        w_set_dirty  = w_store;
                    end else begin
                        w_stall = 1'b1;
                        w_next  = bus.i_dcache_tag_dirty ? S_WB : S_ALLOC;
                    end
                end
            end
            S_WB: begin
                w_stall    = 1'b1;
                w_mem_wren = 1'b1;
                w_addr_sel = 1'b1;
                if (bus.i_dcache_mem_ready) w_next = S_ALLOC;
            end
            S_ALLOC: begin
                w_stall    = 1'b1;
                w_mem_rden = 1'b1;
                if (bus.i_dcache_mem_ready) begin
                    w_refill_wren = 1'b1;
                    w_set_valid   = 1'b1;
                    w_next        = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_dcache_clk) begin
        if (i_riscv_dcache_rst) r_state <= S_IDLE;
        else                    r_state <= w_next;
    end

    // Outputs are forced low for the whole reset cycle, not just after it.
    assign bus.o_dcache_stall       = w_stall       & ~i_riscv_dcache_rst;
    assign bus.o_dcache_mem_rden    = w_mem_rden    & ~i_riscv_dcache_rst;
    assign bus.o_dcache_mem_wren    = w_mem_wren    & ~i_riscv_dcache_rst;
    assign bus.o_dcache_addr_sel    = w_addr_sel    & ~i_riscv_dcache_rst;
    assign bus.o_dcache_cache_wren  = w_cache_wren  & ~i_riscv_dcache_rst;
    assign bus.o_dcache_refill_wren = w_refill_wren & ~i_riscv_dcache_rst;
    assign bus.o_dcache_set_dirty   = w_set_dirty   & ~i_riscv_dcache_rst;
    assign bus.o_dcache_set_valid   = w_set_valid   & ~i_riscv_dcache_rst;

`ifdef DCACHE_PERF_CNT_EN
    logic                 r_replay;
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;
    logic                 w_hit_evt;
    logic                 w_miss_evt;

    // r_replay marks the IDLE cycle right after a refill so its hit is not counted.
    assign w_hit_evt  = (r_state == S_IDLE) & w_req & bus.i_dcache_tag_hit & ~r_replay;
    assign w_miss_evt = (r_state == S_IDLE) & w_req & ~bus.i_dcache_tag_hit;

    always_ff @(posedge i_riscv_dcache_clk) begin
        if (i_riscv_dcache_rst) begin
            r_replay   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_replay <= (r_state == S_ALLOC) & bus.i_dcache_mem_ready;
            if (w_hit_evt)  r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (w_miss_evt) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.o_dcache_hit_cnt  = r_hit_cnt;
    assign bus.o_dcache_miss_cnt = r_miss_cnt;
`endif

    a_req_stable : assert property (@(posedge i_riscv_dcache_clk)
        disable iff (i_riscv_dcache_rst)
        bus.o_dcache_stall |=> ($stable(w_req) && $stable(w_store)));
endmodule

// File: tb/tb_riscv_dcache_fsm.sv
// Scoreboard bench for riscv_dcache_fsm: per-cycle expected output vectors
// are derived from transaction-level rules and checked by a negedge monitor.
module tb_riscv_dcache_fsm;
    localparam logic [7:0] STALL = 8'h80, MRD = 8'h40, MWR = 8'h20, ASEL = 8'h10;
    localparam logic [7:0] CWR   = 8'h08, RFL = 8'h04, SDT = 8'h02, SVL = 8'h01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic [7:0] exp_q[$];
    int   m_hits = 0;
    int   m_miss = 0;

    riscv_dcache_fsm_if bus();

    riscv_dcache_fsm dut (
        .i_riscv_dcache_clk(clk),
        .i_riscv_dcache_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [7:0] act;
        logic [7:0] exp;
        cyc++;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            act = {bus.o_dcache_stall, bus.o_dcache_mem_rden, bus.o_dcache_mem_wren,
                   bus.o_dcache_addr_sel, bus.o_dcache_cache_wren, bus.o_dcache_refill_wren,
                   bus.o_dcache_set_dirty, bus.o_dcache_set_valid};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%b exp=%b (stall,mrd,mwr,asel,cwr,rfl,sdt,svl)",
                         cyc, act, exp);
            end
        end
    end

    // One cycle of stimulus; expected vector queued for the monitor.
    task automatic step(input logic r, input logic rd, input logic wr, input logic hit,
                        input logic dirty, input logic rdy, input logic [7:0] exp);
        rst = r;
        bus.i_dcache_cpu_rden  = rd;
        bus.i_dcache_cpu_wren  = wr;
        bus.i_dcache_tag_hit   = hit;
        bus.i_dcache_tag_dirty = dirty;
        bus.i_dcache_mem_ready = rdy;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), rdy, 8'h00);
    endtask

    task automatic hit_access(input logic rd, input logic wr);
        step(0, rd, wr, 1, $urandom_range(0, 1), $urandom_range(0, 1),
             wr ? (CWR | SDT) : 8'h00);
        m_hits++;
    endtask

    // Miss: one decision cycle, optional writeback of lw cycles, refill of lr
    // cycles (ready on the last one), then the replay hit.
    task automatic miss_access(input logic rd, input logic wr, input logic dirty,
                               input int lw, input int lr);
        step(0, rd, wr, 0, dirty, 0, STALL);
        m_miss++;
        if (dirty)
            for (int i = 0; i < lw; i++)
                step(0, rd, wr, 0, dirty, i == lw - 1, STALL | MWR | ASEL);
        for (int i = 0; i < lr; i++)
            step(0, rd, wr, 0, dirty, i == lr - 1,
                 (i == lr - 1) ? (STALL | MRD | RFL | SVL) : (STALL | MRD));
        step(0, rd, wr, 1, 0, 0, wr ? (CWR | SDT) : 8'h00);
    endtask

    task automatic chk_cnt(input string name);
`ifdef DCACHE_PERF_CNT_EN
        checks++;
        if (bus.o_dcache_hit_cnt != 32'(m_hits) || bus.o_dcache_miss_cnt != 32'(m_miss)) begin
            errors++;
            $display("FAIL %s counters got hit=%0d miss=%0d exp hit=%0d miss=%0d", name,
                     bus.o_dcache_hit_cnt, bus.o_dcache_miss_cnt, m_hits, m_miss);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_dcache_cpu_rden  = 1'b0;
        bus.i_dcache_cpu_wren  = 1'b0;
        bus.i_dcache_tag_hit   = 1'b0;
        bus.i_dcache_tag_dirty = 1'b0;
        bus.i_dcache_mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with a pending missing load; outputs stay low.
        step(1, 1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 1, 8'h00);
        chk_cnt("reset");
        miss_access(1, 0, 0, 0, 1);
        // Four back-to-back load hits, then a store hit.
        repeat (4) hit_access(1, 0);
        hit_access(0, 1);
        idle(1);
        miss_access(1, 0, 0, 0, 3);   // clean load miss, L=3
        miss_access(0, 1, 1, 2, 2);   // dirty store miss, L=2
        miss_access(1, 1, 0, 0, 2);   // rden&wren behaves as a store
        chk_cnt("directed");
        // Reset on the second ALLOCATE cycle aborts the miss.
        step(0, 1, 0, 0, 0, 0, STALL);
        step(0, 1, 0, 0, 0, 0, STALL | MRD);
        step(1, 1, 0, 0, 0, 0, 8'h00);
        m_hits = 0;
        m_miss = 0;
        step(0, 0, 0, 0, 0, 1, 8'h00);  // stray ready is ignored in IDLE
        chk_cnt("abort");
        for (int t = 0; t < 60; t++) begin
            int   k;
            logic wr;
            logic rd;
            k  = $urandom_range(0, 3);
            wr = $urandom_range(0, 1);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            case (k)
                0: idle($urandom_range(0, 1));
                1: hit_access(rd, wr);
                default: miss_access(rd, wr, k == 3, $urandom_range(1, 4), $urandom_range(1, 4));
            endcase
        end
        idle(0);
        chk_cnt("random");
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
